// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, packet geometry and main FSM encoding for the UART command controller.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;

  // opcode + address + little-endian 32-bit payload
  localparam int PKT_LEN_WR  = 6;
  localparam int WDATA_BYTES = PKT_LEN_WR - 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_DATA    = 3'd2,
    S_BUS_REQ = 3'd3,
    S_BUS_REL = 3'd4
  } main_state_e;

endpackage

// File: rtl/uart_byte_hs.sv
// Four-phase req/ack byte receiver: byte_valid/byte_data one cycle after req is accepted.
// While hold is high a pending request is left unacknowledged until hold drops.
module uart_byte_hs (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rec_req,
  input  logic [7:0] uart_data_in,
  input  logic       hold,
  output logic       uart_rec_ack,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  logic       ack_q, ack_d;
  logic       vld_q, vld_d;
  logic [7:0] dat_q, dat_d;

  always_comb begin
    ack_d = ack_q;
    vld_d = 1'b0;
    dat_d = dat_q;
    if (!ack_q) begin
      if (uart_rec_req && !hold) begin
        ack_d = 1'b1;
        vld_d = 1'b1;
        dat_d = uart_data_in;
      end
    end else if (!uart_rec_req) begin
      ack_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_q <= 1'b0;
      vld_q <= 1'b0;
      dat_q <= 8'h00;
    end else begin
      ack_q <= ack_d;
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign uart_rec_ack = ack_q;
  assign byte_valid   = vld_q;
  assign byte_data    = dat_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Decodes UART byte packets (57 addr d0..d3 / 52 addr) into single bus read/write transactions.
// Bus phase waits indefinitely for bus_ack; UART bytes are held off until the bus phase ends.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CNT = 50000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_rec_req,
  output logic        uart_rec_ack,
  input  logic [7:0]  uart_data_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic [7:0]  bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned    TW       = $clog2(TIMEOUT_CNT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CNT - 1);
  localparam logic [1:0]     IDX_LAST = 2'(WDATA_BYTES - 1);

  main_state_e    state_q, state_d;
  logic           we_q, we_d;
  logic [7:0]     addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [1:0]     idx_q, idx_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [31:0]    rd_data_q, rd_data_d;
  logic           rd_valid_q, rd_valid_d;
  logic           frame_err_q, frame_err_d;

  logic           byte_valid;
  logic [7:0]     byte_data;
  logic           hold;
  logic           in_rx;
  logic           tmo_expire;

  assign hold = (state_q == S_BUS_REQ) || (state_q == S_BUS_REL);

  uart_byte_hs u_byte_hs (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .uart_rec_req (uart_rec_req),
    .uart_data_in (uart_data_in),
    .hold         (hold),
    .uart_rec_ack (uart_rec_ack),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data)
  );

  // An arriving byte takes priority over a simultaneous expiry.
  assign in_rx      = (state_q == S_ADDR) || (state_q == S_DATA);
  assign tmo_expire = in_rx && !byte_valid && (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    tmo_d       = (in_rx && !byte_valid && !tmo_expire) ? tmo_q + TW'(1) : '0;

    case (state_q)
      S_IDLE: begin
        if (byte_valid) begin
          if (byte_data == CMD_WR) begin
            we_d    = 1'b1;
            state_d = S_ADDR;
          end else if (byte_data == CMD_RD) begin
            we_d    = 1'b0;
            state_d = S_ADDR;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (byte_valid) begin
          addr_d  = byte_data;
          idx_d   = 2'd0;
          state_d = we_q ? S_DATA : S_BUS_REQ;
        end else if (tmo_expire) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_DATA: begin
        if (byte_valid) begin
          wdata_d[{idx_q, 3'b000} +: 8] = byte_data;
          idx_d = idx_q + 2'd1;
          if (idx_q == IDX_LAST) state_d = S_BUS_REQ;
        end else if (tmo_expire) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_BUS_REQ: begin
        if (bus_ack) begin
          if (!we_q) begin
            rd_data_d  = bus_rdata;
            rd_valid_d = 1'b1;
          end
          state_d = S_BUS_REL;
        end
      end
      S_BUS_REL: begin
        if (!bus_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 32'h0;
      idx_q       <= 2'd0;
      tmo_q       <= '0;
      rd_data_q   <= 32'h0;
      rd_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus_req   = (state_q == S_BUS_REQ);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed + randomized packet bench for uart_cmd_ctrl with a bus slave and packet-level model.
module tb_uart_cmd_ctrl;

  localparam int TMO = 100;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        uart_rec_req = 1'b0;
  logic        uart_rec_ack;
  logic [7:0]  uart_data_in = 8'h00;
  logic        bus_req;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        frame_err;
  logic        busy;

  always #5 sys_clk = ~sys_clk;

  uart_cmd_ctrl #(.TIMEOUT_CNT(TMO)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .uart_rec_req (uart_rec_req),
    .uart_rec_ack (uart_rec_ack),
    .uart_data_in (uart_data_in),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        seen_q[$];
  txn_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          fe_cnt = 0;
  int          rv_cnt = 0;
  int          breq_rise = 0;
  int          stab_err = 0;
  int          ack_delay = 0;
  logic [31:0] last_rd = 32'h0;
  logic [31:0] slave_rdata = 32'h0;
  logic        breq_prev = 1'b0;
  logic [31:0] model_wdata = 32'h0;

  // pulse/edge monitor, sampled mid-cycle
  always @(negedge sys_clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (rd_valid) begin
      rv_cnt  <= rv_cnt + 1;
      last_rd <= rd_data;
    end
    if (bus_req && !breq_prev) breq_rise <= breq_rise + 1;
    breq_prev <= bus_req;
  end

  // bus slave: records the request, delays ack, checks request stability meanwhile
  always begin : slave
    txn_t snap;
    @(posedge sys_clk); #1;
    if (sys_rst_n && bus_req && !bus_ack) begin
      snap = {bus_we, bus_addr, bus_wdata};
      for (int i = 0; i < ack_delay; i++) begin
        @(posedge sys_clk); #1;
        if (!bus_req || ({bus_we, bus_addr, bus_wdata} != snap)) stab_err++;
      end
      seen_q.push_back(snap);
      bus_rdata = slave_rdata;
      bus_ack   = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(posedge sys_clk); #1;
        if (!bus_req) break;
      end
      if (bus_req) stab_err++;
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (observed running, expected done)");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic wait_ack(input logic lvl, input int budget, input string tag);
    int i;
    i = 0;
    while (uart_rec_ack !== lvl && i < budget) begin
      tick(1);
      i++;
    end
    chk(tag, 96'(uart_rec_ack), 96'(lvl));
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_ack(1'b0, 50, "ack_idle");
    uart_rec_req = 1'b1;
    uart_data_in = b;
    wait_ack(1'b1, 200, "ack_rise");
    uart_rec_req = 1'b0;
    uart_data_in = 8'($urandom);
    wait_ack(1'b0, 10, "ack_fall");
  endtask

  task automatic send_write(input logic [7:0] a, input logic [31:0] d);
    send_byte(8'h57);
    tick($urandom_range(0, 5));
    send_byte(a);
    for (int k = 0; k < 4; k++) begin
      tick($urandom_range(0, 5));
      send_byte(d[8*k +: 8]);
    end
  endtask

  task automatic send_read(input logic [7:0] a);
    send_byte(8'h52);
    tick($urandom_range(0, 5));
    send_byte(a);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int i;
    i = 0;
    while (busy && i < budget) begin
      tick(1);
      i++;
    end
    chk(tag, 96'(busy), 96'(0));
  endtask

  task automatic chk_txns(input string tag);
    chk({tag, "_cnt"}, 96'(seen_q.size()), 96'(exp_q.size()));
    if (seen_q.size() == exp_q.size() && seen_q.size() > 0)
      chk(tag, 96'(seen_q[$]), 96'(exp_q[$]));
  endtask

  function automatic logic [95:0] outs_now();
    return 96'({uart_rec_ack, bus_req, bus_we, bus_addr, bus_wdata,
                rd_data, rd_valid, frame_err, busy});
  endfunction

  initial begin
    int f0, r0, b0, hi, i, kind;
    logic [7:0]  a, b;
    logic [31:0] d;

    tick(3);
    chk("reset_outs", outs_now(), 96'(0));
    sys_rst_n = 1'b1;
    tick(2);

    // basic write
    ack_delay = 2;
    b0 = breq_rise;
    exp_q.push_back({1'b1, 8'h10, 32'h12345678});
    model_wdata = 32'h12345678;
    send_write(8'h10, 32'h12345678);
    wait_idle(200, "wr_done");
    chk_txns("wr_txn");
    chk("wr_breq_once", 96'(breq_rise - b0), 96'(1));
    chk("addr_hold", 96'(bus_addr), 96'(8'h10));
    chk("wdata_hold", 96'(bus_wdata), 96'(32'h12345678));

    // basic read
    slave_rdata = 32'hDEADBEEF;
    r0 = rv_cnt;
    exp_q.push_back({1'b0, 8'h20, model_wdata});
    send_read(8'h20);
    wait_idle(200, "rd_done");
    chk_txns("rd_txn");
    chk("rd_data", 96'(rd_data), 96'(32'hDEADBEEF));
    chk("rd_valid_1cyc", 96'(rv_cnt - r0), 96'(1));
    chk("rd_capture", 96'(last_rd), 96'(32'hDEADBEEF));

    // bad opcode
    f0 = fe_cnt;
    b0 = breq_rise;
    send_byte(8'h00);
    tick(3);
    chk("badop_fe", 96'(fe_cnt - f0), 96'(1));
    chk("badop_nobus", 96'(breq_rise - b0), 96'(0));
    chk("badop_idle", 96'(busy), 96'(0));

    // inter-byte timeout
    f0 = fe_cnt;
    send_byte(8'h57);
    send_byte(8'h10);
    tick(95);
    chk("tmo_early", 96'(fe_cnt - f0), 96'(0));
    chk("tmo_busy", 96'(busy), 96'(1));
    tick(10);
    chk("tmo_fe", 96'(fe_cnt - f0), 96'(1));
    chk("tmo_idle", 96'(busy), 96'(0));
    chk_txns("tmo_nobus");
    slave_rdata = $urandom;
    r0 = rv_cnt;
    exp_q.push_back({1'b0, 8'h30, model_wdata});
    send_read(8'h30);
    wait_idle(200, "tmo_rd_done");
    chk_txns("tmo_rd_txn");
    chk("tmo_rd_data", 96'(rd_data), 96'(slave_rdata));

    // byte held off during a slow bus phase
    ack_delay = 40;
    a = $urandom;
    d = $urandom;
    exp_q.push_back({1'b1, a, d});
    model_wdata = d;
    send_write(a, d);
    uart_rec_req = 1'b1;
    uart_data_in = 8'h52;
    hi = 0;
    i = 0;
    while (busy && i < 200) begin
      if (uart_rec_ack) hi++;
      tick(1);
      i++;
    end
    chk("hold_ack_low", 96'(hi), 96'(0));
    chk("hold_long", 96'(i >= 40), 96'(1));
    chk_txns("hold_wr_txn");
    wait_ack(1'b1, 20, "hold_ack_rise");
    uart_rec_req = 1'b0;
    wait_ack(1'b0, 10, "hold_ack_fall");
    ack_delay = 1;
    slave_rdata = $urandom;
    exp_q.push_back({1'b0, 8'h40, model_wdata});
    send_byte(8'h40);
    wait_idle(200, "hold_rd_done");
    chk_txns("hold_rd_txn");
    chk("hold_rd_data", 96'(rd_data), 96'(slave_rdata));

    // reset in the middle of the data phase
    send_byte(8'h57);
    send_byte(8'hAA);
    send_byte(8'h11);
    send_byte(8'h22);
    tick(1);
    f0 = fe_cnt;
    #2 sys_rst_n = 1'b0;
    #1 chk("rst_mid_outs", outs_now(), 96'(0));
    tick(2);
    sys_rst_n = 1'b1;
    tick(2);
    chk("rst_no_fe", 96'(fe_cnt - f0), 96'(0));
    chk_txns("rst_nobus");
    model_wdata = 32'h0;
    a = $urandom;
    d = $urandom;
    exp_q.push_back({1'b1, a, d});
    model_wdata = d;
    send_write(a, d);
    wait_idle(200, "rst_wr_done");
    chk_txns("rst_wr_txn");

    // randomized packet mix
    for (int k = 0; k < 24; k++) begin
      kind = $urandom_range(0, 2);
      ack_delay = $urandom_range(0, 6);
      a = $urandom;
      d = $urandom;
      if (kind == 0) begin
        exp_q.push_back({1'b1, a, d});
        model_wdata = d;
        send_write(a, d);
        wait_idle(200, "rnd_wr_done");
        chk_txns("rnd_wr_txn");
      end else if (kind == 1) begin
        slave_rdata = d;
        r0 = rv_cnt;
        exp_q.push_back({1'b0, a, model_wdata});
        send_read(a);
        wait_idle(200, "rnd_rd_done");
        chk_txns("rnd_rd_txn");
        chk("rnd_rd_data", 96'(rd_data), 96'(d));
        chk("rnd_rd_pulse", 96'(rv_cnt - r0), 96'(1));
      end else begin
        b = $urandom;
        while (b == 8'h57 || b == 8'h52) b = $urandom;
        f0 = fe_cnt;
        send_byte(b);
        tick(2);
        chk("rnd_badop_fe", 96'(fe_cnt - f0), 96'(1));
        chk("rnd_badop_idle", 96'(busy), 96'(0));
      end
    end

    chk("bus_stable", 96'(stab_err), 96'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CNT, default 50000, giving the inter-byte timeout in sys_clk cycles (1 ms at 50 MHz).
REQ-002 SHALL have port sys_clk, input, 1, the single clock for all state.
REQ-003 SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port uart_rec_req, input, 1, byte-available level from the UART receiver.
REQ-005 SHALL have port uart_rec_ack, output, 1, byte-consumed acknowledge to the UART receiver.
REQ-006 SHALL have port uart_data_in, input, 8, received byte; valid while uart_rec_req=1.
REQ-007 SHALL have port bus_req, output, 1, bus transaction request level.
REQ-008 SHALL have port bus_we, output, 1, 1=write, 0=read.
REQ-009 SHALL have port bus_addr, output, 8, transaction address.
REQ-010 SHALL have port bus_wdata, output, 32, write data.
REQ-011 SHALL have port bus_ack, input, 1, bus completion level.
REQ-012 SHALL have port bus_rdata, input, 32, read data; valid while bus_ack=1.
REQ-013 SHALL have port rd_data, output, 32, last captured read data.
REQ-014 SHALL have port rd_valid, output, 1, one-cycle pulse when rd_data updates.
REQ-015 SHALL have port frame_err, output, 1, one-cycle pulse on bad opcode or timeout.
REQ-016 SHALL have port busy, output, 1, high whenever the main FSM is not in IDLE.

Function
REQ-017 SHALL run a four-phase UART byte handshake: when uart_rec_req=1 and uart_rec_ack=0, capture uart_data_in, assert uart_rec_ack next cycle, and pulse byte_valid for one cycle.
REQ-018 SHALL hold uart_rec_ack high until uart_rec_req is sampled low, then drop it the following cycle.
REQ-019 SHALL not start a new byte handshake while the main FSM is in BUS_REQ or BUS_REL; the request stays pending and is serviced on return to IDLE.
REQ-020 SHALL implement the packet format: byte0 opcode (8'h57 write, 8'h52 read), byte1 address, and for write only, bytes 2..5 data, little-endian (byte2 = wdata[7:0]).
REQ-021 SHALL use main FSM states IDLE, ADDR, DATA, BUS_REQ, BUS_REL.
REQ-022 IDLE SHALL transition as follows: valid write opcode -> ADDR with we=1; valid read opcode -> ADDR with we=0; any other byte -> pulse frame_err and stay in IDLE.
REQ-023 ADDR SHALL, on byte_valid, load bus_addr, then go to DATA when we=1 or to BUS_REQ when we=0.
REQ-024 DATA SHALL use a 2-bit byte index 0..3, loading bus_wdata lanes in order, and go to BUS_REQ after index 3.
REQ-025 SHALL assert bus_req on the cycle of entry to BUS_REQ and hold bus_we, bus_addr and bus_wdata stable until bus_ack is sampled high.
REQ-026 On bus_ack=1 in BUS_REQ, SHALL deassert bus_req; for a read, latch bus_rdata into rd_data and pulse rd_valid in the same cycle; then go to BUS_REL.
REQ-027 BUS_REL SHALL wait for bus_ack=0, then go to IDLE.
REQ-028 SHALL run the timeout counter only in ADDR and DATA, clear it on every byte_valid and on entry to those states, and on reaching TIMEOUT_CNT-1 pulse frame_err and return to IDLE, discarding the partial packet.
REQ-029 If byte_valid and timeout expiry fall in the same cycle, the byte SHALL win, with no error raised.
REQ-030 SHALL leave bus_wdata and bus_addr holding their last values outside BUS_REQ, with no clearing.

Reset
REQ-031 On sys_rst_n=0, SHALL set all of the following to 0 asynchronously: uart_rec_ack, bus_req, bus_we, bus_addr, bus_wdata, rd_data, rd_valid, frame_err, busy, the counters, and FSM=IDLE.
REQ-032 Reset mid-packet or mid-bus-transaction SHALL drop the packet without a frame_err pulse.

Structure
REQ-033 SHALL take opcode constants CMD_WR=8'h57 and CMD_RD=8'h52, the main FSM state encoding, and the packet length from a shared package uart_cmd_pkg.
REQ-034 SHALL place the byte handshake (REQ-017..019) in sub-module uart_byte_hs, with outputs byte_valid and byte_data and input hold.

Verification
REQ-035 SHALL cover this scenario: bytes 57,10,78,56,34,12 -> one bus_req with we=1, addr=8'h10, wdata=32'h12345678; after ack, busy=0.
REQ-036 SHALL cover this scenario: bytes 52,20; bus_ack with rdata=32'hDEADBEEF -> rd_data=32'hDEADBEEF, rd_valid high exactly 1 cycle.
REQ-037 SHALL cover this scenario: byte 8'h00 in IDLE -> single frame_err pulse, no bus_req, uart_rec_ack still completes.
REQ-038 SHALL cover this scenario: with TIMEOUT_CNT=100, bytes 57,10 then 100-cycle silence -> frame_err pulse, FSM back to IDLE; subsequent 52,30 produces a read to 8'h30.
REQ-039 SHALL cover this scenario: a byte presented while bus_ack is delayed 40 cycles -> uart_rec_ack stays low until IDLE, then the byte is accepted.
REQ-040 SHALL cover this scenario: sys_rst_n pulsed low while in DATA index 2 -> all outputs 0 immediately, no frame_err, the next full packet executes correctly.
